// File: rtl/l2_control_pkg.sv
// l2_control_pkg: shared state type and sizing for the L2 cache controller
package l2_control_pkg;
    localparam int L2_NUM_SETS = 8;
    typedef enum logic [2:0] {INIT, IDLE, CHECK, WRITEBACK, FILL} l2_state_t;
endpackage

// File: rtl/l2_lru.sv
// l2_lru: per-set 1-bit LRU file with combinational read and one write port
module l2_lru
    import l2_control_pkg::*;
#(
    parameter int NUM_SETS = L2_NUM_SETS,
    parameter int IDX_W = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] index,
    input  logic             din,
    output logic             dout
);
    logic [NUM_SETS-1:0] bits;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bits <= '0;
        else if (we) bits[index] <= din;
    assign dout = bits[index];
endmodule

// File: rtl/l2_control.sv
// l2_control: sequencing FSM, set-clear counter and victim latch for the 2-way write-back L2
module l2_control
    import l2_control_pkg::*;
#(
    parameter int NUM_SETS = L2_NUM_SETS,
    parameter int IDX_W = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [IDX_W-1:0] index,
    input  logic [1:0]       hit,
    input  logic [1:0]       valid,
    input  logic [1:0]       dirty,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [1:0]       load_v,
    output logic [1:0]       load_d,
    output logic [1:0]       load_TD,
    output logic             v_in,
    output logic             d_in,
    output logic             data_sel,
    output logic             addr_sel,
    output logic             way_sel,
    output logic             index_sel,
    output logic [IDX_W-1:0] init_index,
    output logic             busy
);
    l2_state_t        state;
    logic [IDX_W-1:0] cnt;
    logic             victim, lru_out, hit_way;
    logic             in_init, chk_hit, chk_wr, in_wb, in_fill, fill_done;
    logic [1:0]       hit_oh, vic_oh;
    l2_lru #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) u_lru (
        .clk(clk),
        .rst_n(rst_n),
        .we(chk_hit),
        .index(index),
        .din(~hit_way),
        .dout(lru_out)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= INIT;
            cnt    <= '0;
            victim <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    cnt   <= (cnt == IDX_W'(NUM_SETS - 1)) ? '0 : cnt + 1'b1;
                    state <= (cnt == IDX_W'(NUM_SETS - 1)) ? IDLE : INIT;
                end
                IDLE: state <= (mem_read || mem_write) ? CHECK : IDLE;
                CHECK: begin
                    victim <= (|hit) ? victim : lru_out;
                    state  <= (|hit) ? IDLE : (valid[lru_out] && dirty[lru_out]) ? WRITEBACK : FILL;
                end
                WRITEBACK: state <= pmem_resp ? FILL : WRITEBACK;
                FILL: state <= pmem_resp ? CHECK : FILL;
                default: state <= INIT;
            endcase
        end
    // every strobe and request is gated by rst_n so nothing leaks out while reset is held
    assign in_init    = rst_n && state == INIT;
    assign chk_hit    = rst_n && state == CHECK && |hit;
    assign chk_wr     = chk_hit && mem_write;
    assign in_wb      = rst_n && state == WRITEBACK;
    assign in_fill    = rst_n && state == FILL;
    assign fill_done  = in_fill && pmem_resp;
    assign hit_way    = ~hit[0];
    assign hit_oh     = hit_way ? 2'b10 : 2'b01;
    assign vic_oh     = victim ? 2'b10 : 2'b01;
    assign mem_resp   = chk_hit;
    assign pmem_write = in_wb;
    assign pmem_read  = in_fill;
    assign addr_sel   = in_wb;
    assign way_sel    = chk_hit ? hit_way : victim;
    assign load_TD    = chk_wr ? hit_oh : fill_done ? vic_oh : 2'b00;
    assign load_d     = in_init ? 2'b11 : load_TD;
    assign load_v     = in_init ? 2'b11 : fill_done ? vic_oh : 2'b00;
    assign v_in       = fill_done;
    assign d_in       = chk_wr;
    assign data_sel   = chk_wr;
    assign index_sel  = in_init;
    assign init_index = cnt;
    assign busy       = state != IDLE;
endmodule

// File: tb/tb_l2_control.sv
// tb_l2_control: randomized bench with a datapath stand-in and a behavioural 2-way LRU cache model
module tb_l2_control;
    localparam int NS = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0, pm_hold = 1'b0;
    logic [2:0] index = '0;
    logic [7:0] cur_tag = '0;
    logic [1:0] hit, valid, dirty, load_v, load_d, load_TD;
    logic mem_resp, pmem_read, pmem_write, v_in, d_in, data_sel, addr_sel, way_sel, index_sel, busy;
    logic [2:0] init_index, dp_idx;
    int n_tests = 0, n_fail = 0;
    logic [7:0] dp_tag [NS][2];
    logic dp_v [NS][2];
    logic dp_d [NS][2];
    int ref_tag [NS][2];
    bit ref_v [NS][2];
    bit ref_d [NS][2];
    bit ref_lru [NS];
    int neg_n = 0, wb_n = 0, fill_n = 0, last_fill = 0, proto_bad = 0, wb_way = 0;
    logic [1:0] f_ltd, f_lv, f_ld;
    logic f_vin, f_din, f_ds;

    always #5 clk = ~clk;

    l2_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .index(index), .hit(hit), .valid(valid), .dirty(dirty), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp), .load_v(load_v), .load_d(load_d),
        .load_TD(load_TD), .v_in(v_in), .d_in(d_in), .data_sel(data_sel), .addr_sel(addr_sel),
        .way_sel(way_sel), .index_sel(index_sel), .init_index(init_index), .busy(busy)
    );

    // stand-in for the two l2_way arrays and tag comparators; scrambled while reset is held
    assign dp_idx = index_sel ? init_index : index;
    always_comb
        for (int w = 0; w < 2; w++) begin
            valid[w] = dp_v[index][w];
            dirty[w] = dp_d[index][w];
            hit[w]   = dp_v[index][w] && dp_tag[index][w] == cur_tag;
        end
    always @(posedge clk)
        if (!rst_n) begin
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < 2; w++) begin
                    dp_tag[s][w] <= 8'($urandom_range(0, 5));
                    dp_v[s][w]   <= 1'($urandom_range(0, 1));
                    dp_d[s][w]   <= 1'($urandom_range(0, 1));
                end
        end else
            for (int w = 0; w < 2; w++) begin
                if (load_TD[w]) dp_tag[dp_idx][w] <= cur_tag;
                if (load_v[w]) dp_v[dp_idx][w] <= v_in;
                if (load_d[w]) dp_d[dp_idx][w] <= d_in;
            end

    // physical memory: random-latency one-cycle response
    initial forever begin
        @(negedge clk);
        pmem_resp = rst_n && !pm_hold && (pmem_read || pmem_write) && !pmem_resp && $urandom_range(0, 2) == 0;
    end

    always @(negedge clk) begin
        #1;
        neg_n++;
        if (rst_n) begin
            if ((pmem_write && !addr_sel) || (pmem_read && addr_sel) || (pmem_read && pmem_write) ||
                (mem_resp && (pmem_read || pmem_write))) proto_bad++;
            if (pmem_write && pmem_resp) begin
                wb_n++;
                wb_way = int'(way_sel);
            end
            if (pmem_read && pmem_resp) begin
                fill_n++;
                last_fill = neg_n;
                f_ltd = load_TD;
                f_lv  = load_v;
                f_ld  = load_d;
                f_vin = v_in;
                f_din = d_in;
                f_ds  = data_sel;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_clear();
        for (int s = 0; s < NS; s++) begin
            ref_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                ref_v[s][w] = 1'b0;
                ref_d[s][w] = 1'b0;
                ref_tag[s][w] = 0;
            end
        end
    endtask

    task automatic check_init();
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            #2;
            check("init_index", 32'(init_index), 32'(i));
            check("init_load_v", 32'(load_v), 32'h3);
            check("init_load_d", 32'(load_d), 32'h3);
            check("init_vin_din_isel_busy", 32'({v_in, d_in, index_sel, busy}), 32'h3);
        end
        @(negedge clk);
        #2;
        check("init_to_idle", 32'(busy), 32'h0);
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] idx, input logic [7:0] tg);
        int way, vic, lat, t0, wb0, fill0, pb0, resp_neg;
        bit hit_r, wb_exp, got, is_wr;
        logic [1:0] ltd, ld;
        logic ws, dn, ds;
        logic [9:0] got_l, exp_l;
        is_wr = wr;
        hit_r = 1'b0;
        way = 0;
        for (int w = 1; w >= 0; w--)
            if (ref_v[idx][w] && ref_tag[idx][w] == int'(tg)) begin
                hit_r = 1'b1;
                way = w;
            end
        vic = int'(ref_lru[idx]);
        wb_exp = !hit_r && ref_v[idx][vic] && ref_d[idx][vic];
        if (!hit_r) way = vic;
        @(posedge clk);
        #1;
        mem_read = rd;
        mem_write = wr;
        index = idx;
        cur_tag = tg;
        t0 = neg_n;
        wb0 = wb_n;
        fill0 = fill_n;
        pb0 = proto_bad;
        got = 1'b0;
        lat = 0;
        resp_neg = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            #2;
            if (mem_resp) begin
                got = 1'b1;
                lat = neg_n - t0;
                resp_neg = neg_n;
                ltd = load_TD;
                ld = load_d;
                ws = way_sel;
                dn = d_in;
                ds = data_sel;
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        check("mem_resp_seen", 32'(got), 32'h1);
        check("writebacks", 32'(wb_n - wb0), 32'(wb_exp));
        check("fills", 32'(fill_n - fill0), 32'(!hit_r));
        check("protocol", 32'(proto_bad - pb0), 32'h0);
        check("resp_way_sel", 32'(ws), 32'(way));
        check("resp_load_TD", 32'(ltd), is_wr ? 32'(1 << way) : 32'h0);
        check("resp_load_d", 32'(ld), is_wr ? 32'(1 << way) : 32'h0);
        check("resp_din_datasel", 32'({dn, ds}), is_wr ? 32'h3 : 32'h0);
        if (hit_r) check("hit_latency", 32'(lat), 32'h2);
        else begin
            check("fill_to_resp", 32'(resp_neg - last_fill), 32'h1);
            check("fill_load_TD", 32'(f_ltd), 32'(1 << way));
            check("fill_load_v", 32'(f_lv), 32'(1 << way));
            check("fill_load_d", 32'(f_ld), 32'(1 << way));
            check("fill_vin_din_ds", 32'({f_vin, f_din, f_ds}), 32'h4);
        end
        if (wb_exp) check("wb_way", 32'(wb_way), 32'(vic));
        ref_tag[idx][way] = int'(tg);
        ref_d[idx][way] = (hit_r && ref_d[idx][way]) || is_wr;
        ref_v[idx][way] = 1'b1;
        ref_lru[idx] = (way == 0);
        for (int w = 0; w < 2; w++) begin
            got_l = {dp_v[idx][w], dp_v[idx][w] & dp_d[idx][w], dp_v[idx][w] ? dp_tag[idx][w] : 8'h0};
            exp_l = {ref_v[idx][w], ref_v[idx][w] & ref_d[idx][w], ref_v[idx][w] ? 8'(ref_tag[idx][w]) : 8'h0};
            check("set_contents", 32'(got_l), 32'(exp_l));
        end
    endtask

    initial begin
        bit seen;
        logic rd, wr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_quiet", 32'({load_v, load_d, load_TD, pmem_read, pmem_write, mem_resp}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_clear();
        check_init();
        req(1'b1, 1'b0, 3'd3, 8'd1);
        req(1'b1, 1'b0, 3'd3, 8'd2);
        req(1'b1, 1'b1, 3'd3, 8'd1);
        req(1'b1, 1'b0, 3'd5, 8'd1);
        req(1'b1, 1'b0, 3'd5, 8'd2);
        req(1'b0, 1'b1, 3'd5, 8'd2);
        req(1'b1, 1'b0, 3'd5, 8'd3);
        req(1'b1, 1'b0, 3'd5, 8'd4);
        pm_hold = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b1;
        index = 3'd2;
        cur_tag = 8'd7;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #2;
            seen = pmem_read;
        end
        check("fill_before_reset", 32'(seen), 32'h1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_pmem", 32'({pmem_read, pmem_write, mem_resp, load_TD, load_v, load_d}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_held_quiet", 32'({pmem_read, pmem_write, mem_resp, load_TD, load_v, load_d}), 32'h0);
        mem_read = 1'b0;
        pm_hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_clear();
        check_init();
        for (int n = 0; n < 250; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            req(rd, wr, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 5)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
